// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - E-stage request and HI/LO result bundle for the multiply/divide unit
interface mul_div_unit_if;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  MDUOp;
    logic        start_E;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (
        output in1, in2, MDUOp, start_E,
        input  hi, lo, busy
    );

    modport slave (
        input  in1, in2, MDUOp, start_E,
        output hi, lo, busy
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - fixed-latency multiply/divide unit owning the architectural HI/LO registers
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi_p;
    logic [31:0] lo_p;
    logic        commit_p;

    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic        [31:0] u_den;
    logic        [31:0] u_quo;
    logic        [31:0] u_rem;
    logic               a_neg;
    logic               b_neg;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] s_quo_mag;
    logic        [31:0] s_rem_mag;
    logic        [31:0] s_quo;
    logic        [31:0] s_rem;
    logic               den_zero;

    logic               is_start;
    logic        [31:0] res_hi;
    logic        [31:0] res_lo;
    logic        [3:0]  res_lat;
    logic               res_commit;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case.
    always_comb begin
        s_prod    = $signed({{32{bus.in1[31]}}, bus.in1}) * $signed({{32{bus.in2[31]}}, bus.in2});
        u_prod    = {32'd0, bus.in1} * {32'd0, bus.in2};
        den_zero  = (bus.in2 == 32'd0);
        u_den     = den_zero ? 32'd1 : bus.in2;
        u_quo     = bus.in1 / u_den;
        u_rem     = bus.in1 % u_den;
        a_neg     = bus.in1[31];
        b_neg     = bus.in2[31];
        a_mag     = a_neg ? (32'd0 - bus.in1) : bus.in1;
        b_mag     = b_neg ? (32'd0 - bus.in2) : bus.in2;
        if (den_zero) begin
            b_mag = 32'd1;
        end
        s_quo_mag = a_mag / b_mag;
        s_rem_mag = a_mag % b_mag;
        s_quo     = (a_neg ^ b_neg) ? (32'd0 - s_quo_mag) : s_quo_mag;
        s_rem     = a_neg ? (32'd0 - s_rem_mag) : s_rem_mag;
    end

    always_comb begin
        is_start   = 1'b0;
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        res_lat    = MULT_LAT;
        res_commit = 1'b1;
        if (bus.start_E) begin
            case (bus.MDUOp)
                OP_MULT: begin
                    is_start = 1'b1;
                    res_hi   = s_prod[63:32];
                    res_lo   = s_prod[31:0];
                end
                OP_MULTU: begin
                    is_start = 1'b1;
                    res_hi   = u_prod[63:32];
                    res_lo   = u_prod[31:0];
                end
                OP_DIV: begin
                    is_start   = 1'b1;
                    res_hi     = s_rem;
                    res_lo     = s_quo;
                    res_lat    = DIV_LAT;
                    res_commit = !den_zero;
                end
                OP_DIVU: begin
                    is_start   = 1'b1;
                    res_hi     = u_rem;
                    res_lo     = u_quo;
                    res_lat    = DIV_LAT;
                    res_commit = !den_zero;
                end
                default: begin
                    is_start = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            hi_p     <= 32'd0;
            lo_p     <= 32'd0;
            commit_p <= 1'b0;
            bus.hi   <= 32'd0;
            bus.lo   <= 32'd0;
            bus.busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_start) begin
                        hi_p     <= res_hi;
                        lo_p     <= res_lo;
                        commit_p <= res_commit;
                        cnt      <= res_lat;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else if (!bus.start_E && bus.MDUOp == OP_MTHI) begin
                        bus.hi <= bus.in1;
                    end else if (!bus.start_E && bus.MDUOp == OP_MTLO) begin
                        bus.lo <= bus.in1;
                    end
                end
                RUN: begin
                    // Requests arriving here are dropped; the CPU is stalled on busy.
                    if (cnt <= 4'd1) begin
                        if (commit_p) begin
                            bus.hi <= hi_p;
                            bus.lo <= lo_p;
                        end
                        cnt      <= 4'd0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    mul_div_unit_if bus();

    mul_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in1     = a;
        bus.in2     = b;
        bus.MDUOp   = op;
        bus.start_E = 1'b1;
        @(posedge clk);
        #1;
        bus.start_E = 1'b0;
        bus.MDUOp   = 4'd0;
    endtask

    task automatic write_hilo(input logic [3:0] op, input logic [31:0] val);
        bus.in1     = val;
        bus.MDUOp   = op;
        bus.start_E = 1'b0;
        @(posedge clk);
        #1;
        bus.MDUOp   = 4'd0;
    endtask

    // Counts busy cycles sampled on falling edges, and notes whether HI/LO moved while busy.
    task automatic count_busy(output int n, output bit held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0   = bus.hi;
        l0   = bus.lo;
        n    = 0;
        held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_held: got %b want 0", bus.busy); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 00000000", bus.hi); end
        n_cmp++;
        if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 00000000", bus.lo); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_mult;
        int n;
        bit held;
        do_start(4'd1, 32'hFFFF_FFFD, 32'd5);
        count_busy(n, held);
        n_cmp++;
        if (n !== 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
        n_cmp++;
        if (held !== 1'b1) begin n_fail++; $display("FAIL mult_hilo_held: got %b want 1", held); end
        n_cmp++;
        if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
        n_cmp++;
        if (bus.lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo: got %h want fffffff1", bus.lo); end

        do_start(4'd2, 32'hFFFF_FFFF, 32'd2);
        count_busy(n, held);
        n_cmp++;
        if (n !== 5) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
        n_cmp++;
        if (bus.hi !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi: got %h want 00000001", bus.hi); end
        n_cmp++;
        if (bus.lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffe", bus.lo); end
    endtask

    task automatic test_div;
        int n;
        bit held;
        do_start(4'd3, 32'hFFFF_FFF9, 32'd2);
        count_busy(n, held);
        n_cmp++;
        if (n !== 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
        n_cmp++;
        if (held !== 1'b1) begin n_fail++; $display("FAIL div_hilo_held: got %b want 1", held); end
        n_cmp++;
        if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", bus.lo); end
        n_cmp++;
        if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", bus.hi); end

        do_start(4'd3, 32'd7, 32'hFFFF_FFFE);
        count_busy(n, held);
        n_cmp++;
        if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negdiv_lo: got %h want fffffffd", bus.lo); end
        n_cmp++;
        if (bus.hi !== 32'h0000_0001) begin n_fail++; $display("FAIL div_negdiv_hi: got %h want 00000001", bus.hi); end

        do_start(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n, held);
        n_cmp++;
        if (bus.lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", bus.lo); end
        n_cmp++;
        if (bus.hi !== 32'h0000_0000) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 00000000", bus.hi); end

        do_start(4'd4, 32'd7, 32'd2);
        count_busy(n, held);
        n_cmp++;
        if (n !== 10) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d want 10", n); end
        n_cmp++;
        if (bus.lo !== 32'd3) begin n_fail++; $display("FAIL divu_lo: got %h want 00000003", bus.lo); end
        n_cmp++;
        if (bus.hi !== 32'd1) begin n_fail++; $display("FAIL divu_hi: got %h want 00000001", bus.hi); end
    endtask

    task automatic test_div_zero;
        int n;
        bit held;
        write_hilo(4'd5, 32'h11);
        n_cmp++;
        if (bus.hi !== 32'h11) begin n_fail++; $display("FAIL mthi_write: got %h want 00000011", bus.hi); end
        write_hilo(4'd6, 32'h22);
        n_cmp++;
        if (bus.lo !== 32'h22) begin n_fail++; $display("FAIL mtlo_write: got %h want 00000022", bus.lo); end
        do_start(4'd4, 32'd7, 32'd0);
        count_busy(n, held);
        n_cmp++;
        if (n !== 10) begin n_fail++; $display("FAIL divzero_busy_cycles: got %0d want 10", n); end
        n_cmp++;
        if (bus.hi !== 32'h11) begin n_fail++; $display("FAIL divzero_hi: got %h want 00000011", bus.hi); end
        n_cmp++;
        if (bus.lo !== 32'h22) begin n_fail++; $display("FAIL divzero_lo: got %h want 00000022", bus.lo); end
    endtask

    task automatic test_reserved_ops;
        bus.in1     = 32'h99;
        bus.in2     = 32'd3;
        bus.MDUOp   = 4'd5;
        bus.start_E = 1'b1;
        @(posedge clk);
        #1;
        bus.MDUOp   = 4'd9;
        @(posedge clk);
        #1;
        bus.start_E = 1'b0;
        @(posedge clk);
        #1;
        bus.MDUOp   = 4'd0;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reserved_busy: got %b want 0", bus.busy); end
        n_cmp++;
        if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            n_fail++;
            $display("FAIL reserved_hilo: got %h/%h want 00000011/00000022", bus.hi, bus.lo);
        end
    endtask

    task automatic test_ignored_in_run;
        int n;
        do_start(4'd1, 32'd3, 32'd4);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
            if (i == 1) begin
                bus.MDUOp   = 4'd5;
                bus.in1     = 32'hAA;
                bus.start_E = 1'b0;
            end else if (i == 2) begin
                bus.MDUOp   = 4'd3;
                bus.in1     = 32'd9;
                bus.in2     = 32'd3;
                bus.start_E = 1'b1;
            end else begin
                bus.MDUOp   = 4'd0;
                bus.start_E = 1'b0;
            end
        end
        bus.MDUOp   = 4'd0;
        bus.start_E = 1'b0;
        n_cmp++;
        if (n !== 5) begin n_fail++; $display("FAIL ignored_busy_cycles: got %0d want 5", n); end
        n_cmp++;
        if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL ignored_hi: got %h want 00000000", bus.hi); end
        n_cmp++;
        if (bus.lo !== 32'd12) begin n_fail++; $display("FAIL ignored_lo: got %h want 0000000c", bus.lo); end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignored_no_restart: got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back;
        int n;
        bit held;
        do_start(4'd2, 32'h0001_0000, 32'h0001_0000);
        count_busy(n, held);
        do_start(4'd4, 32'd100, 32'd7);
        n_cmp++;
        if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_first_result: got %h/%h want 00000001/00000000", bus.hi, bus.lo);
        end
        count_busy(n, held);
        n_cmp++;
        if (n !== 10) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 10", n); end
        n_cmp++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_second_result: got %h/%h want 00000002/0000000e", bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_mid;
        bit clean;
        write_hilo(4'd5, 32'h5);
        write_hilo(4'd6, 32'h5);
        do_start(4'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_hilo: got %h/%h want 00000000/00000000", bus.hi, bus.lo);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        reset = 1'b1;
        clean = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) clean = 1'b0;
        end
        n_cmp++;
        if (clean !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_no_commit: got busy=%b hi=%h lo=%h want 0/0/0", bus.busy, bus.hi, bus.lo);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        reset       = 1'b0;
        bus.in1     = 32'd0;
        bus.in2     = 32'd0;
        bus.MDUOp   = 4'd0;
        bus.start_E = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_reserved_ops();
        test_ignored_in_run();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide responder on the E-stage `start`/`busy` handshake of the pipelined CPU datapath. It accepts one MDU operation per `start` pulse and holds `busy` for a fixed latency, during which the hazard unit stalls dependent instructions. It commits results into the architectural HI/LO registers, which feed M-stage forwarding and W-stage register write-back.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy duration for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy duration for div/divu; legal range 1..15.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `in1` input 32: operand A, the forwarded rs value.
- `in2` input 32: operand B, the forwarded rt value.
- `MDUOp` input 4: operation code. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7..15 reserved and treated as none.
- `start_E` input 1: one-cycle request qualifier, valid only with MDUOp 1..4.
- `hi` output 32: architectural HI register.
- `lo` output 32: architectural LO register.
- `busy` output 1: operation in progress.

## Operation

- States: IDLE and RUN. A 4-bit down-counter `cnt`, plus pending registers `hi_p` and `lo_p`.
- **Start from IDLE:** at the edge where `start_E`=1 and `MDUOp` is 1..4:
  - compute the result from `in1`/`in2` sampled at that edge into `hi_p`/`lo_p`;
  - load `cnt` with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- `start_E`=1 with any other MDUOp code is ignored.
- **mult:** signed 32x32 to 64, {hi,lo}. **multu:** unsigned.
- **div:** signed; lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- **divu:** unsigned quotient in lo, remainder in hi.
- **Divide by zero (div/divu, in2=0):** the unit still enters RUN for DIV_CYCLES, but `hi`/`lo` are left unchanged at commit.
- **RUN:** `cnt` decrements each edge. At the edge where `cnt` goes from 1 to 0, commit `hi_p`→`hi` and `lo_p`→`lo`, then return to IDLE.
- **mthi/mtlo:** in IDLE with `start_E`=0 and MDUOp=5 (or 6), write `in1` to `hi` (or `lo`) at the edge. They are ignored in RUN, because the CPU stalls them.
- **Start while in RUN:** ignored. The in-flight operation is unaffected.
- `hi`/`lo` hold their old values throughout RUN. There is no early or partial visibility.
- **Reset mid-operation:** abort immediately, return to IDLE, discard the pending result.

## Timing

- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `cnt`=0, state IDLE. They apply asynchronously on `reset`=0 and are held until release.
- **Start timing:** a start accepted at edge N gives `busy`=1 from just after edge N until just after edge N+L, with L = MULT_CYCLES or DIV_CYCLES. `busy` is therefore high for exactly L cycles.
- **Commit timing:** `hi`/`lo` take new values at edge N+L, the same edge at which `busy` falls.
- **Back-to-back:** a new start is accepted at edge N+L+1 at the earliest, since `busy` is sampled low in that cycle.
- **Combinational start:** `busy` is a registered output. The CPU must stall on `start_E|busy` for the cycle of the start itself.
- **mthi/mtlo:** single-cycle; the new value is visible after the writing edge.
- No combinational path exists from inputs to any output.

## Test plan

- **Reset:** drive `reset`=0 for 2 cycles, then release → `hi`=0, `lo`=0, `busy`=0.
- **mult:**
  - in1=0xFFFFFFFD (−3), in2=5, start at edge N → `busy` high for 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1 at edge N+5.
  - Repeat as multu with 0xFFFFFFFF×2 → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- **div:**
  - −7 / 2 → after 10 busy cycles, `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - divu 7/2 → `lo`=3, `hi`=1.
- **Divide by zero:** preload `hi`=0x11, `lo`=0x22 via mthi/mtlo, then divu 7/0 → `busy` high for 10 cycles; `hi`=0x11, `lo`=0x22 unchanged.
- **Ignored requests in RUN:** during a mult, issue mthi in1=0xAA and a second start (div 9/3) → both are ignored. The mult result commits at N+5, and `busy` falls after exactly 5 cycles.
- **Reset mid-operation:** assert `reset` at cycle 3 of a div with prior `hi`=`lo`=0x5 → outputs go to 0 immediately. After release, `busy`=0, and no commit occurs at the original N+10.
